// File: rtl/kv_pkg.sv
// Shared types and entry-layout helpers for the key/value slot controller.
package kv_pkg;

  typedef enum logic [1:0] {
    OP_GET  = 2'b00,
    OP_PUT  = 2'b01,
    OP_DEL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_MISS  = 2'b01,
    ST_FULL  = 2'b10,
    ST_BADOP = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOOKUP = 2'b01,
    S_EXEC   = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  // Slot layout, MSB to LSB: {valid, key, value}.
  function automatic int entry_width(input int key_w, input int value_w);
    return 1 + key_w + value_w;
  endfunction

  function automatic int valid_pos(input int key_w, input int value_w);
    return key_w + value_w;
  endfunction

  function automatic int key_lsb(input int value_w);
    return value_w;
  endfunction

endpackage

// File: rtl/kv_match_encoder.sv
// Combinational key search over all slots; lowest index wins for both the
// hit and the first free slot.
module kv_match_encoder
  import kv_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  parameter  int KEY_WIDTH   = 16,
  parameter  int VALUE_WIDTH = 32,
  localparam int ENTRY_W     = entry_width(KEY_WIDTH, VALUE_WIDTH),
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES*ENTRY_W-1:0] slot_rdata,
  input  logic [KEY_WIDTH-1:0]           key,
  output logic                           hit,
  output logic [IDX_W-1:0]               hit_idx,
  output logic                           any_free,
  output logic [IDX_W-1:0]               free_idx
);

  localparam int VPOS = valid_pos(KEY_WIDTH, VALUE_WIDTH);
  localparam int KLSB = key_lsb(VALUE_WIDTH);

  // Scan high to low so the last assignment is the lowest matching index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (slot_rdata[i*ENTRY_W + VPOS]) begin
        if (slot_rdata[i*ENTRY_W + KLSB +: KEY_WIDTH] == key) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
      end else begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/kv_slot_controller.sv
// Command front-end for the slot register arrays: one GET/PUT/DEL in flight,
// IDLE -> LOOKUP -> EXEC -> RESP, strobes driven only during EXEC.
module kv_slot_controller
  import kv_pkg::*;
#(
  parameter  int NUM_ENTRIES = 8,
  parameter  int KEY_WIDTH   = 16,
  parameter  int VALUE_WIDTH = 32,
  localparam int ENTRY_W     = entry_width(KEY_WIDTH, VALUE_WIDTH),
  localparam int FC_W        = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [KEY_WIDTH-1:0]           cmd_key,
  input  logic [VALUE_WIDTH-1:0]         cmd_value,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [1:0]                     rsp_status,
  output logic [VALUE_WIDTH-1:0]         rsp_value,
  output logic [FC_W-1:0]                fill_count,
  output logic [NUM_ENTRIES-1:0]         slot_write,
  output logic [NUM_ENTRIES-1:0]         slot_select,
  output logic [ENTRY_W-1:0]             slot_wdata,
  input  logic [NUM_ENTRIES*ENTRY_W-1:0] slot_rdata
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  state_e                 state, state_next;

  op_e                    op_p0;
  logic [KEY_WIDTH-1:0]   key_p0;
  logic [VALUE_WIDTH-1:0] value_p0;

  logic                   hit_p1;
  logic [IDX_W-1:0]       hit_idx_p1;
  logic                   any_free_p1;
  logic [IDX_W-1:0]       free_idx_p1;
  logic [VALUE_WIDTH-1:0] hit_value_p1;

  status_e                rsp_status_p2;
  logic [VALUE_WIDTH-1:0] rsp_value_p2;
  logic [FC_W-1:0]        fill_q;

  logic                   enc_hit;
  logic [IDX_W-1:0]       enc_hit_idx;
  logic                   enc_any_free;
  logic [IDX_W-1:0]       enc_free_idx;
  logic [VALUE_WIDTH-1:0] lookup_value;

  logic                   exec_select;
  logic                   exec_write;
  logic [IDX_W-1:0]       exec_idx;
  logic [ENTRY_W-1:0]     exec_wdata;
  status_e                exec_status;
  logic [VALUE_WIDTH-1:0] exec_value;
  logic                   fill_inc;
  logic                   fill_dec;
  logic                   strobe_en;

  // Occupancy step that can never wrap past either end.
  function automatic logic [FC_W-1:0] fill_step(input logic [FC_W-1:0] cnt,
                                                input logic inc,
                                                input logic dec);
    if (inc && (cnt < FC_W'(NUM_ENTRIES))) return cnt + FC_W'(1);
    if (dec && (cnt != '0))                return cnt - FC_W'(1);
    return cnt;
  endfunction

  kv_match_encoder #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .KEY_WIDTH   (KEY_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_match (
    .slot_rdata (slot_rdata),
    .key        (key_p0),
    .hit        (enc_hit),
    .hit_idx    (enc_hit_idx),
    .any_free   (enc_any_free),
    .free_idx   (enc_free_idx)
  );

  // Value field of the slot the encoder reports as the hit.
  always_comb begin
    lookup_value = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (enc_hit_idx == IDX_W'(i)) lookup_value = slot_rdata[i*ENTRY_W +: VALUE_WIDTH];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: state_next = S_EXEC;
      S_EXEC:   state_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Stage p0: capture the accepted command.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cmd_valid) begin
      op_p0    <= op_e'(cmd_op);
      key_p0   <= cmd_key;
      value_p0 <= cmd_value;
    end
  end

  // Stage p1: register the search result; a reserved op never reports a hit.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP) begin
      hit_p1       <= enc_hit && (op_p0 != OP_RSVD);
      hit_idx_p1   <= enc_hit_idx;
      any_free_p1  <= enc_any_free;
      free_idx_p1  <= enc_free_idx;
      hit_value_p1 <= lookup_value;
    end
  end

  // Action decode for EXEC from the registered search result.
  always_comb begin
    exec_select = 1'b0;
    exec_write  = 1'b0;
    exec_idx    = hit_idx_p1;
    exec_wdata  = '0;
    exec_status = ST_OK;
    exec_value  = '0;
    fill_inc    = 1'b0;
    fill_dec    = 1'b0;
    case (op_p0)
      OP_PUT: begin
        exec_wdata = {1'b1, key_p0, value_p0};
        if (hit_p1) begin
          exec_select = 1'b1;
          exec_write  = 1'b1;
        end else if (any_free_p1) begin
          exec_select = 1'b1;
          exec_write  = 1'b1;
          exec_idx    = free_idx_p1;
          fill_inc    = 1'b1;
        end else begin
          exec_status = ST_FULL;
        end
      end
      OP_DEL: begin
        if (hit_p1) begin
          exec_select = 1'b1;
          exec_write  = 1'b1;
          fill_dec    = 1'b1;
        end else begin
          exec_status = ST_MISS;
        end
      end
      OP_GET: begin
        if (hit_p1) begin
          exec_select = 1'b1;
          exec_value  = hit_value_p1;
        end else begin
          exec_status = ST_MISS;
        end
      end
      OP_RSVD: exec_status = ST_BADOP;
    endcase
  end

  // Strobes exist only in EXEC and are suppressed while reset is applied.
  always_comb begin
    strobe_en   = (state == S_EXEC) && rst_n;
    slot_select = '0;
    slot_write  = '0;
    slot_wdata  = '0;
    if (strobe_en) begin
      if (exec_select) slot_select = NUM_ENTRIES'(1) << exec_idx;
      if (exec_write)  slot_write  = NUM_ENTRIES'(1) << exec_idx;
      if (exec_write)  slot_wdata  = exec_wdata;
    end
  end

  // Stage p2: response and occupancy update on the EXEC -> RESP edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_status_p2 <= ST_OK;
      rsp_value_p2  <= '0;
      fill_q        <= '0;
    end else if (state == S_EXEC) begin
      rsp_status_p2 <= exec_status;
      rsp_value_p2  <= exec_value;
      fill_q        <= fill_step(fill_q, fill_inc, fill_dec);
    end
  end

  assign rsp_status = rsp_status_p2;
  assign rsp_value  = rsp_value_p2;
  assign fill_count = fill_q;

endmodule

// File: doc/kv_slot_controller.md
Name: kv_slot_controller

Overview:
- Command front-end of the cache memory; sits directly upstream of the per-slot dynamic_register_array instances.
- Accepts GET/PUT/DEL commands over a valid/ready handshake and searches all slots for the key.
- Drives the per-slot write_op/select_op strobes and shared write data, then returns a response over a second valid/ready handshake.
- Each slot stores one entry, packed MSB to LSB as {valid, key, value}.

Parameters:
- NUM_ENTRIES, 8, number of slots (register array instances); must be ≥ 2.
- KEY_WIDTH, 16, key width in bits.
- VALUE_WIDTH, 32, value width in bits.
- ENTRY_W (localparam), 1+KEY_WIDTH+VALUE_WIDTH, slot width; passed as LENGTH to each array.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 GET, 01 PUT, 10 DEL, 11 reserved.
- cmd_key  in  KEY_WIDTH  lookup key.
- cmd_value  in  VALUE_WIDTH  PUT data; ignored for other ops.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_status  out  2  00 OK, 01 MISS, 10 FULL, 11 BADOP.
- rsp_value  out  VALUE_WIDTH  GET data; 0 unless GET hit.
- fill_count  out  $clog2(NUM_ENTRIES+1)  number of valid slots.
- slot_write  out  NUM_ENTRIES  per-slot write_op.
- slot_select  out  NUM_ENTRIES  per-slot select_op, one-hot or zero.
- slot_wdata  out  ENTRY_W  shared data_in for all slots.
- slot_rdata  in  NUM_ENTRIES*ENTRY_W  concatenated data_out; slot i occupies bits [i*ENTRY_W +: ENTRY_W].

Behaviour:
- Reset values:
  - state IDLE.
  - cmd_ready = 1 in the cycle after reset deasserts; held 0 while rst_n is low.
  - rsp_valid = 0, rsp_status = 0, rsp_value = 0.
  - fill_count = 0.
  - slot_write = 0, slot_select = 0, slot_wdata = 0.
- Reset mid-operation aborts the command with no response; the arrays clear on the same rst_n.
- FSM: IDLE → LOOKUP → EXEC → RESP → IDLE. One command is in flight at a time; there is no pipelining.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch op/key/value into registers and go to LOOKUP.
- LOOKUP (1 cycle):
  - Compare the latched key against every slot with valid=1.
  - Register hit, hit_idx (lowest matching index) and free_idx (lowest index with valid=0, plus any_free).
  - Register the hit slot's value.
- EXEC (1 cycle), decide the action and its strobes:
  - PUT hit: slot_select[hit_idx]=1, slot_write[hit_idx]=1, slot_wdata={1,key,value}; status OK; fill_count unchanged.
  - PUT miss with any_free: same strobes on free_idx; status OK; fill_count+1.
  - PUT miss, no free slot: no strobes; status FULL.
  - DEL hit: strobes on hit_idx, slot_wdata=0; status OK; fill_count−1.
  - DEL miss: status MISS, no strobes.
  - GET hit: slot_select[hit_idx]=1, slot_write=0; status OK; rsp_value = stored value.
  - GET miss: status MISS, rsp_value=0.
  - op 11: status BADOP, no strobes, no lookup side effects.
  - Strobes are asserted only in EXEC and are zero in all other states.
  - The array updates on the EXEC→RESP edge, so the new contents are visible in RESP.
- RESP:
  - rsp_valid=1 with status/value held stable until rsp_ready.
  - On rsp_valid && rsp_ready go to IDLE.
  - cmd_ready=0 throughout.
- Latency: command accepted at cycle 0 → rsp_valid at cycle 3 (3 clk edges later) when there is no backpressure. Best-case throughput is one command per 4 cycles.
- Duplicate valid keys never arise through this controller; if present, the lowest index wins.
- fill_count saturates at NUM_ENTRIES and 0 by construction; it never wraps.

Decomposition:
- Package kv_pkg holds:
  - op_e (GET/PUT/DEL/RSVD).
  - status_e (OK/MISS/FULL/BADOP).
  - state_e (IDLE/LOOKUP/EXEC/RESP).
  - Entry field-offset helpers from KEY_WIDTH/VALUE_WIDTH.
- Sub-module kv_match_encoder (combinational): inputs slot_rdata and key; outputs hit, hit_idx, any_free, free_idx, using lowest-index priority.

Test Plan:
- Reset, then PUT key 0x0011 value 0xDEADBEEF → rsp at cycle 3: OK; slot_write=0x01 in EXEC; fill_count=1.
- GET 0x0011 → OK, rsp_value=0xDEADBEEF, slot_write=0; GET 0x0022 → MISS, rsp_value=0.
- PUT 0x0011 value 0x12345678 → rewrites slot 0, fill_count stays 1; a following GET returns 0x12345678.
- Fill 8 distinct keys → fill_count=8; 9th PUT → FULL with no strobes. DEL the key in slot 3 → OK, fill_count=7. Next PUT of a new key → lands in slot 3 (slot_select=0x08).
- Hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, cmd_ready=0, cmd_valid ignored. Op 11 → BADOP with no writes.
- Assert rst_n=0 during EXEC of a PUT → next cycle all outputs at reset values, fill_count=0, no response issued.
